ula_multiciclo_n_bits: RTL
==========================

// Module: ula_multiciclo_n_bits
// PURPOSE
//  Parametrised multi-cycle ULA. Extends the 16-function arithmetic/logic set (M/S/Cin) to WIDTH bits.
//  Processes one 4-bit slice per clock, LSB slice first, with the carry registered between slices.
//  Wrapped in valid/ready handshakes so the ULA can sit between pipeline stages of the datapath.
// PARAMETERS
//  WIDTH   16   operand width; multiple of 4, >= 8
//  SLICES  WIDTH/4   derived (localparam); number of slice cycles per operation
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  in_valid  in   1      operands/command valid
//  in_ready  out  1      block can accept a command
//  a, b      in   WIDTH  operands
//  s         in   4      function select
//  m         in   1      1=logic, 0=arithmetic
//  c_in      in   1      active-high carry into LSB (arithmetic only)
//  out_valid out  1      result valid
//  out_ready in   1      consumer accepts result
//  f         out  WIDTH  result
//  c_out     out  1      carry out (see rules)
//  overflow  out  1      signed overflow
//  a_eq_b    out  1      &f
//  zero, neg out  1      only with ULA_ZN_FLAGS_EN
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=1; out_valid=0; f, c_out, overflow, a_eq_b (and zero, neg) = 0; all internal regs cleared.
//  FSM IDLE -> CALC on in_valid&&in_ready; a, b, s, m, c_in captured on that edge; carry reg := c_in.
//  CALC: each edge computes slice k (k=0..SLICES-1) into f[4k+:4] and updates the carry reg.
//    After the last slice: -> DONE; out_valid=1 exactly SLICES cycles after the accept edge.
//  DONE: outputs held stable while out_valid && !out_ready.
//    On out_ready: out_valid drops. If in_valid is also high, the new command is accepted the same edge -> CALC; else -> IDLE.
//    Sustained throughput: one op per SLICES+1 cycles.
//  in_ready = (state==IDLE) || (state==DONE && out_ready). in_valid is ignored in CALC (no queueing).
//  Arithmetic (m=0): f = X + Y + c_in, taken mod 2^WIDTH; 1s = all-ones WIDTH vector.
//    0000 A+1s | 0001 A+(A|B) | 0010 (A|B)+1s | 0011 0+1s | 0100 A+(A&B) | 0101 (A|B)+(A&B)
//    0110 A+~B | 0111 (A&~B)+1s | 1000 A+(A&~B) | 1001 A+B | 1010 (A|~B)+(A&B) | 1011 (A&B)+1s
//    1100 A+A | 1101 (A|B)+A | 1110 (A|~B)+A | 1111 A+0
//  c_out = carry from MSB. It is complemented for s in {0000,0010,0011,0110,0111,1011}, direct otherwise.
//  overflow (MSB = bit WIDTH-1):
//    s=1001: a[MSB]==b[MSB] && f[MSB]!=a[MSB]
//    s=0110: a[MSB]!=b[MSB] && f[MSB]==b[MSB]
//    0 for all other s.
//  Logic (m=1), bitwise:
//    0000 ~A | 0001 ~(A|B) | 0010 ~A&B | 0011 0 | 0100 ~(A&B) | 0101 ~B | 0110 A^B | 0111 A&~B
//    1000 A&B | 1001 ~(A^B) | 1010 B | 1011 ~A|B | 1100 1s | 1101 A|~B | 1110 A|B | 1111 A
//    c_out=0 and overflow=0 in logic mode; no carry propagates between slices.
//  Flags update only on entry to DONE. Reset asserted mid-CALC aborts the op immediately; no result is issued.
// CONFIGURATION
//  ULA_ZN_FLAGS_EN defined: adds ports zero (f==0) and neg (f[MSB]), registered with f.
//  ULA_ZN_FLAGS_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Package ula_pkg: typedef enum {IDLE,CALC,DONE} ula_state_t; localparams for the S codes and the complemented-carry S set.
//  Sub-module ula_fatia_4_bits: combinational 4-bit slice (a, b, s, m, cin -> f, cout), instantiated once and reused each cycle.
// TESTING (WIDTH=16)
//  1. m=0 s=1001 A=7FFF B=0001 cin=0 -> f=8000 c_out=0 overflow=1; out_valid 4 cycles after accept.
//  2. m=0 s=1001 A=FFFF B=0001 cin=0 -> f=0000 c_out=1 overflow=0 a_eq_b=0 (zero=1 if enabled).
//  3. m=0 s=0110 A=1234 B=1234 cin=0 -> f=FFFF a_eq_b=1 c_out=1; then cin=1 -> f=0000 c_out=0.
//  4. m=1 s=0110 A=AAAA B=5555 -> f=FFFF c_out=0 overflow=0; sweep all s, m, cin against a reference model.
//  5. Backpressure: out_ready=0 for 10 cycles -> f stable, in_ready=0; release with in_valid=1 -> new op accepted same edge.
//  6. rst_n pulsed low during CALC slice 2 -> out_valid=0, in_ready=1, f=0; no stale result afterwards.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared state type, function-select codes and carry-polarity helper for the multi-cycle ULA.
package ula_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} ula_state_t;
  localparam logic [3:0] S_A_MAIS_1S   = 4'b0000;
  localparam logic [3:0] S_OU_MAIS_1S  = 4'b0010;
  localparam logic [3:0] S_ZERO_MAIS_1S = 4'b0011;
  localparam logic [3:0] S_SUB         = 4'b0110;
  localparam logic [3:0] S_ANB_MAIS_1S = 4'b0111;
  localparam logic [3:0] S_ADD         = 4'b1001;
  localparam logic [3:0] S_AB_MAIS_1S  = 4'b1011;
  function automatic logic carry_invertido(input logic [3:0] s);
    return s == S_A_MAIS_1S || s == S_OU_MAIS_1S || s == S_ZERO_MAIS_1S ||
           s == S_SUB || s == S_ANB_MAIS_1S || s == S_AB_MAIS_1S;
  endfunction
endpackage

// File: rtl/ula_fatia_4_bits.sv
// ula_fatia_4_bits: combinational 4-bit ULA slice; arithmetic is X+Y+cin, logic mode ignores cin and drives cout=0.
module ula_fatia_4_bits
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout
);
  logic [3:0] x, y, l;
  logic [4:0] sum;
  always_comb begin
    x = a;
    y = '0;
    case (s)
      4'b0000: begin x = a;       y = '1;      end
      4'b0001: begin x = a;       y = a | b;   end
      4'b0010: begin x = a | b;   y = '1;      end
      4'b0011: begin x = '0;      y = '1;      end
      4'b0100: begin x = a;       y = a & b;   end
      4'b0101: begin x = a | b;   y = a & b;   end
      4'b0110: begin x = a;       y = ~b;      end
      4'b0111: begin x = a & ~b;  y = '1;      end
      4'b1000: begin x = a;       y = a & ~b;  end
      4'b1001: begin x = a;       y = b;       end
      4'b1010: begin x = a | ~b;  y = a & b;   end
      4'b1011: begin x = a & b;   y = '1;      end
      4'b1100: begin x = a;       y = a;       end
      4'b1101: begin x = a | b;   y = a;       end
      4'b1110: begin x = a | ~b;  y = a;       end
      default: begin x = a;       y = '0;      end
    endcase
  end
  always_comb begin
    l = a;
    case (s)
      4'b0000: l = ~a;
      4'b0001: l = ~(a | b);
      4'b0010: l = ~a & b;
      4'b0011: l = '0;
      4'b0100: l = ~(a & b);
      4'b0101: l = ~b;
      4'b0110: l = a ^ b;
      4'b0111: l = a & ~b;
      4'b1000: l = a & b;
      4'b1001: l = ~(a ^ b);
      4'b1010: l = b;
      4'b1011: l = ~a | b;
      4'b1100: l = '1;
      4'b1101: l = a | ~b;
      4'b1110: l = a | b;
      default: l = a;
    endcase
  end
  assign sum  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
  assign f    = m ? l : sum[3:0];
  assign cout = m ? 1'b0 : sum[4];
endmodule

// File: rtl/ula_multiciclo_n_bits.sv
// ula_multiciclo_n_bits: WIDTH-bit ULA evaluated one 4-bit slice per clock behind valid/ready handshakes.
// Define ULA_ZN_FLAGS_EN to add the zero/neg result flags.
module ula_multiciclo_n_bits
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             overflow,
  output logic             a_eq_b
`ifdef ULA_ZN_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);
  localparam int SLICES = WIDTH / 4;
  localparam int CW = $clog2(SLICES);
  ula_state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-5:0] acc;
  logic [3:0] s_r, sf;
  logic m_r, carry, sc, accept, last, ov;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] f_full;
  // Operands shift right so the active slice is always in the low nibble.
  ula_fatia_4_bits u_fatia (
    .a(a_sh[3:0]),
    .b(b_sh[3:0]),
    .s(s_r),
    .m(m_r),
    .cin(carry),
    .f(sf),
    .cout(sc)
  );
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = cnt == CW'(SLICES - 1);
  assign f_full   = {sf, acc};
  // On the last slice the low nibble of the shifted operands holds the MSBs.
  always_comb
    ov = m_r ? 1'b0 :
         s_r == S_ADD ? (a_sh[3] == b_sh[3] && sf[3] != a_sh[3]) :
         s_r == S_SUB ? (a_sh[3] != b_sh[3] && sf[3] == b_sh[3]) : 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      s_r       <= '0;
      m_r       <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      f         <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      a_eq_b    <= 1'b0;
`ifdef ULA_ZN_FLAGS_EN
      zero      <= 1'b0;
      neg       <= 1'b0;
`endif
    end else if (accept) begin
      state     <= CALC;
      a_sh      <= a;
      b_sh      <= b;
      s_r       <= s;
      m_r       <= m;
      carry     <= c_in;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (state == CALC) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      acc   <= f_full[WIDTH-1:4];
      carry <= sc;
      cnt   <= cnt + 1'b1;
      if (last) begin
        state     <= DONE;
        out_valid <= 1'b1;
        f         <= f_full;
        c_out     <= m_r ? 1'b0 : (carry_invertido(s_r) ? ~sc : sc);
        overflow  <= ov;
        a_eq_b    <= &f_full;
`ifdef ULA_ZN_FLAGS_EN
        zero      <= f_full == '0;
        neg       <= f_full[WIDTH-1];
`endif
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule
